// File: rtl/load_store_unit.sv
// Load/store unit: serialises one core load/store into 1/2/4 byte transactions on a
// byte-wide memory bus, assembles load data little-endian and returns one response.
module load_store_unit #(
    parameter int ADDR_W      = 32,
    parameter bit CHECK_ALIGN = 1'b1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [2:0]        req_op,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [31:0]       req_wdata,
    output logic              resp_valid,
    output logic [31:0]       resp_rdata,
    output logic              resp_err,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [7:0]        mem_wdata,
    input  logic [7:0]        mem_rdata,
    input  logic              mem_ack
);

    typedef enum logic [1:0] {
        IDLE,
        ACCESS,
        RESP
    } state_t;

    typedef enum logic [2:0] {
        OP_LB  = 3'b000,
        OP_LH  = 3'b001,
        OP_LW  = 3'b010,
        OP_LBU = 3'b011,
        OP_LHU = 3'b100,
        OP_SB  = 3'b101,
        OP_SH  = 3'b110,
        OP_SW  = 3'b111
    } op_t;

    // Index of the final byte of an access: 0, 1 or 3.
    function automatic logic [1:0] last_index(input op_t op);
        case (op)
            OP_LB, OP_LBU, OP_SB: return 2'd0;
            OP_LH, OP_LHU, OP_SH: return 2'd1;
            default:              return 2'd3;
        endcase
    endfunction

    function automatic logic is_misaligned(input op_t op, input logic [1:0] addr_lo);
        case (last_index(op))
            2'd1:    return addr_lo[0];
            2'd3:    return addr_lo != 2'b00;
            default: return 1'b0;
        endcase
    endfunction

    state_t            state, state_next;
    op_t               op_q;
    logic [ADDR_W-1:0] addr_q;
    logic [31:0]       wdata_q;
    logic [31:0]       load_buf;
    logic [31:0]       load_buf_next;
    logic [31:0]       ext_data;
    logic [1:0]        idx;
    logic [1:0]        last_idx_q;
    logic              accept;
    logic              align_err;
    logic              is_store;
    logic              byte_done;

    assign accept    = req_valid && (state == IDLE);
    assign align_err = CHECK_ALIGN && is_misaligned(op_t'(req_op), req_addr[1:0]);
    assign is_store  = op_q[2] && (op_q != OP_LHU);
    assign byte_done = (state == ACCESS) && mem_ack;

    // Load buffer with the byte arriving this cycle merged in, so the final
    // byte can be extended and registered on the same edge it is acknowledged.
    always_comb begin
        load_buf_next = load_buf;
        load_buf_next[{idx, 3'b000} +: 8] = mem_rdata;
    end

    always_comb begin
        case (op_q)
            OP_LB:   ext_data = {{24{load_buf_next[7]}}, load_buf_next[7:0]};
            OP_LBU:  ext_data = {24'h0, load_buf_next[7:0]};
            OP_LH:   ext_data = {{16{load_buf_next[15]}}, load_buf_next[15:0]};
            OP_LHU:  ext_data = {16'h0, load_buf_next[15:0]};
            OP_LW:   ext_data = load_buf_next;
            default: ext_data = 32'h0;
        endcase
    end

    // NOTE: every output of this block gets a default before the case so no path leaves a latch.
    always_comb begin
        state_next = state;
        req_ready  = 1'b0;
        resp_valid = 1'b0;
        mem_req    = 1'b0;
        mem_we     = 1'b0;
        mem_addr   = '0;
        mem_wdata  = 8'h0;
        case (state)
            IDLE: begin
                req_ready = 1'b1;
                if (accept) begin
                    state_next = align_err ? RESP : ACCESS;
                end
            end
            ACCESS: begin
                mem_req   = 1'b1;
                mem_we    = is_store;
                mem_addr  = addr_q + ADDR_W'(idx);
                mem_wdata = wdata_q[{idx, 3'b000} +: 8];
                if (mem_ack && (idx == last_idx_q)) begin
                    state_next = RESP;
                end
            end
            RESP: begin
                resp_valid = 1'b1;
                state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    // NOTE: registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            op_q       <= OP_LB;
            addr_q     <= '0;
            wdata_q    <= 32'h0;
            load_buf   <= 32'h0;
            idx        <= 2'd0;
            last_idx_q <= 2'd0;
            resp_rdata <= 32'h0;
            resp_err   <= 1'b0;
        end else begin
            state <= state_next;
            if (accept) begin
                op_q       <= op_t'(req_op);
                addr_q     <= req_addr;
                wdata_q    <= req_wdata;
                load_buf   <= 32'h0;
                idx        <= 2'd0;
                last_idx_q <= last_index(op_t'(req_op));
                if (align_err) begin
                    resp_rdata <= 32'h0;
                    resp_err   <= 1'b1;
                end
            end
            if (byte_done) begin
                if (!is_store) begin
                    load_buf <= load_buf_next;
                end
                if (idx == last_idx_q) begin
                    resp_rdata <= ext_data;
                    resp_err   <= 1'b0;
                end else begin
                    idx <= idx + 2'd1;
                end
            end
        end
    end

endmodule

// File: tb/tb_load_store_unit.sv
// Bench for load_store_unit: two instances (alignment check on / off) against a byte
// memory model with configurable wait states and a transaction-level reference model.
module tb_load_store_unit;

    typedef struct packed {
        logic        port;
        logic        we;
        logic [31:0] addr;
        logic [7:0]  data;
    } txn_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        req_valid  [2];
    logic        req_ready  [2];
    logic [2:0]  req_op     [2];
    logic [31:0] req_addr   [2];
    logic [31:0] req_wdata  [2];
    logic        resp_valid [2];
    logic [31:0] resp_rdata [2];
    logic        resp_err   [2];
    logic        mem_req    [2];
    logic        mem_we     [2];
    logic [31:0] mem_addr   [2];
    logic [7:0]  mem_wdata  [2];
    logic [7:0]  mem_rdata  [2];
    logic        mem_ack    [2];

    int   checks = 0;
    int   failures = 0;
    int   unstable = 0;
    int   wait_cfg [2];
    bit   ack_always [2];
    int   wcnt [2];
    bit   hold_pend [2];
    txn_t held [2];
    txn_t log_q [$];
    logic [7:0] mem [logic [31:0]];

    always #5 clk = ~clk;

    load_store_unit #(.ADDR_W(32), .CHECK_ALIGN(1'b1)) dut_chk (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid[0]), .req_ready(req_ready[0]), .req_op(req_op[0]),
        .req_addr(req_addr[0]), .req_wdata(req_wdata[0]),
        .resp_valid(resp_valid[0]), .resp_rdata(resp_rdata[0]), .resp_err(resp_err[0]),
        .mem_req(mem_req[0]), .mem_we(mem_we[0]), .mem_addr(mem_addr[0]),
        .mem_wdata(mem_wdata[0]), .mem_rdata(mem_rdata[0]), .mem_ack(mem_ack[0])
    );

    load_store_unit #(.ADDR_W(32), .CHECK_ALIGN(1'b0)) dut_raw (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid[1]), .req_ready(req_ready[1]), .req_op(req_op[1]),
        .req_addr(req_addr[1]), .req_wdata(req_wdata[1]),
        .resp_valid(resp_valid[1]), .resp_rdata(resp_rdata[1]), .resp_err(resp_err[1]),
        .mem_req(mem_req[1]), .mem_we(mem_we[1]), .mem_addr(mem_addr[1]),
        .mem_wdata(mem_wdata[1]), .mem_rdata(mem_rdata[1]), .mem_ack(mem_ack[1])
    );

    function automatic logic [7:0] rd(input logic [31:0] a);
        return mem.exists(a) ? mem[a] : 8'h00;
    endfunction

    // Memory responder: ack and read data change on the falling edge.
    always @(negedge clk) begin
        for (int k = 0; k < 2; k++) begin
            mem_ack[k]   = ack_always[k] || (mem_req[k] && (wcnt[k] >= wait_cfg[k]));
            mem_rdata[k] = rd(mem_addr[k]);
        end
    end

    // Bus monitor: logs completed byte transactions, performs writes, checks hold stability.
    always @(posedge clk) begin
        txn_t cur;
        for (int k = 0; k < 2; k++) begin
            cur = '{port: k[0], we: mem_we[k], addr: mem_addr[k],
                    data: (mem_we[k] ? mem_wdata[k] : 8'h00)};
            if (hold_pend[k] && mem_req[k] && (cur !== held[k])) unstable++;
            hold_pend[k] = mem_req[k] && !mem_ack[k];
            held[k]      = cur;
            if (mem_req[k] && mem_ack[k]) begin
                log_q.push_back(cur);
                if (mem_we[k]) mem[mem_addr[k]] = mem_wdata[k];
                wcnt[k] = 0;
            end else if (mem_req[k]) begin
                wcnt[k]++;
            end else begin
                wcnt[k] = 0;
            end
        end
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One request end to end, with expectations derived from the memory contents beforehand.
    task automatic run_req(input int k, input logic [2:0] op, input logic [31:0] addr,
                           input logic [31:0] wdata, input int w, input bit ack_hi,
                           output logic [31:0] got);
        int          n;
        int          lat;
        int          c;
        bit          err;
        bit          store;
        logic [31:0] raw;
        logic [31:0] exp_rd;
        txn_t        exp_q [$];

        n     = (op == 3'd0 || op == 3'd3 || op == 3'd5) ? 1 :
                (op == 3'd1 || op == 3'd4 || op == 3'd6) ? 2 : 4;
        store = (op == 3'd5 || op == 3'd6 || op == 3'd7);
        err   = (k == 0) && ((addr % n) != 0);
        raw   = 32'h0;
        for (int i = 0; i < n; i++) raw = raw + (32'(rd(addr + 32'(i))) << (8 * i));
        case (op)
            3'd0:    exp_rd = raw[7]  ? raw - 32'h100   : raw;
            3'd1:    exp_rd = raw[15] ? raw - 32'h10000 : raw;
            3'd2, 3'd3, 3'd4: exp_rd = raw;
            default: exp_rd = 32'h0;
        endcase
        if (err) exp_rd = 32'h0;
        if (!err) begin
            for (int i = 0; i < n; i++) begin
                exp_q.push_back('{port: k[0], we: store, addr: addr + 32'(i),
                                  data: (store ? 8'((wdata >> (8 * i)) & 32'hFF) : 8'h00)});
            end
        end
        lat = err ? 1 : n * ((ack_hi ? 0 : w) + 1) + 1;

        wait_cfg[k]   = w;
        ack_always[k] = ack_hi;
        log_q.delete();
        @(negedge clk);
        req_op[k]    = op;
        req_addr[k]  = addr;
        req_wdata[k] = wdata;
        req_valid[k] = 1'b1;
        check("req_ready_idle", 64'(req_ready[k]), 64'd1);
        @(posedge clk);
        @(negedge clk);
        req_valid[k] = 1'b0;
        c = 1;
        while (!resp_valid[k] && c <= 64) begin
            @(negedge clk);
            c++;
        end
        check($sformatf("latency op=%0d addr=%0h", op, addr), 64'(c), 64'(lat));
        check($sformatf("rdata op=%0d addr=%0h", op, addr), 64'(resp_rdata[k]), 64'(exp_rd));
        check("resp_err", 64'(resp_err[k]), 64'(err));
        check("byte_count", 64'(log_q.size()), 64'(exp_q.size()));
        for (int i = 0; i < exp_q.size() && i < log_q.size(); i++) begin
            check($sformatf("bus_txn%0d", i), 64'(log_q[i]), 64'(exp_q[i]));
        end
        got = resp_rdata[k];
        @(negedge clk);
        check("resp_pulse_one_cycle", 64'(resp_valid[k]), 64'd0);
        check("ready_after_resp", 64'(req_ready[k]), 64'd1);
        check("rdata_held", 64'(resp_rdata[k]), 64'(got));
    endtask

    initial begin
        logic [31:0] got;
        int          k;
        int          w;
        bit          stray;

        for (int i = 0; i < 2; i++) begin
            req_valid[i] = 1'b0; req_op[i] = 3'd0; req_addr[i] = 32'h0; req_wdata[i] = 32'h0;
            wait_cfg[i] = 0; ack_always[i] = 1'b0; wcnt[i] = 0; hold_pend[i] = 1'b0;
        end
        #12;
        for (int i = 0; i < 2; i++) begin
            check("rst_req_ready",  64'(req_ready[i]),  64'd1);
            check("rst_resp_valid", 64'(resp_valid[i]), 64'd0);
            check("rst_resp_rdata", 64'(resp_rdata[i]), 64'd0);
            check("rst_resp_err",   64'(resp_err[i]),   64'd0);
            check("rst_mem_bus", 64'({mem_req[i], mem_we[i], mem_addr[i], mem_wdata[i]}), 64'd0);
        end
        @(negedge clk);
        rst_n = 1'b1;

        mem[32'h10] = 8'h11; mem[32'h11] = 8'h22; mem[32'h12] = 8'h33; mem[32'h13] = 8'h44;
        mem[32'h20] = 8'h80; mem[32'h22] = 8'h00; mem[32'h23] = 8'hF0;
        mem[32'h44] = 8'h5A;
        for (int a = 32'h100; a < 32'h150; a++) mem[32'(a)] = 8'($urandom);

        run_req(0, 3'b010, 32'h10, 32'h0, 0, 1'b1, got);
        check("lw_value", 64'(got), 64'h44332211);
        run_req(0, 3'b000, 32'h20, 32'h0, 0, 1'b1, got);
        check("lb_value", 64'(got), 64'hFFFFFF80);
        run_req(0, 3'b011, 32'h20, 32'h0, 0, 1'b1, got);
        check("lbu_value", 64'(got), 64'h00000080);
        run_req(0, 3'b001, 32'h22, 32'h0, 0, 1'b1, got);
        check("lh_value", 64'(got), 64'hFFFFF000);
        run_req(0, 3'b100, 32'h22, 32'h0, 0, 1'b1, got);
        check("lhu_value", 64'(got), 64'h0000F000);
        run_req(0, 3'b111, 32'h40, 32'hDEADBEEF, 0, 1'b1, got);
        check("sw_mem_word", 64'({rd(32'h43), rd(32'h42), rd(32'h41), rd(32'h40)}), 64'hDEADBEEF);
        run_req(0, 3'b010, 32'h41, 32'h0, 0, 1'b1, got);
        run_req(1, 3'b010, 32'h41, 32'h0, 0, 1'b1, got);
        check("lw_misaligned_raw", 64'(got), 64'h5ADEADBE);
        run_req(0, 3'b110, 32'h8, 32'h0000CAFE, 3, 1'b0, got);
        run_req(1, 3'b111, 32'hFFFFFFFF, 32'h01020304, 1, 1'b0, got);
        check("wrap_mem_byte0", 64'(rd(32'h0)), 64'h03);

        // Reset in the middle of a word load, after two bytes have been acknowledged.
        wait_cfg[0] = 0; ack_always[0] = 1'b1; log_q.delete();
        @(negedge clk);
        req_op[0] = 3'b010; req_addr[0] = 32'h10; req_valid[0] = 1'b1;
        @(posedge clk);
        @(negedge clk);
        req_valid[0] = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #1 rst_n = 1'b0;
        #1;
        check("rst_mid_mem_req", 64'(mem_req[0]), 64'd0);
        check("rst_mid_acks", 64'(log_q.size()), 64'd2);
        @(negedge clk);
        rst_n = 1'b1;
        stray = 1'b0;
        repeat (6) begin
            @(negedge clk);
            if (resp_valid[0]) stray = 1'b1;
        end
        check("rst_mid_no_resp", 64'(stray), 64'd0);
        run_req(0, 3'b010, 32'h10, 32'h0, 0, 1'b1, got);
        check("lw_after_reset", 64'(got), 64'h44332211);

        for (int t = 0; t < 60; t++) begin
            k = int'($urandom_range(0, 1));
            w = int'($urandom_range(0, 2));
            run_req(k, 3'($urandom), 32'h100 + 32'($urandom_range(0, 63)), $urandom, w,
                    (w == 0) && $urandom_range(0, 1) == 1, got);
        end

        check("hold_stability", 64'(unstable), 64'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
